gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist: RTL and testbench

Built-in self-test harness for the 12-track 3.3 V negative-edge flip-flop. It drives a DEPTH-long shift chain of dffn_1 cells from an on-block LFSR pattern generator, which is the upstream stage. It checks the chain output against a reference LFSR, which is the downstream stage. It reports an error count, the first failing index and a pass flag. It sits in the library characterization/test-chip wrapper, one instance per chain under test.

---
 rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_pkg.sv | 21 ++
 rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_if.sv | 28 ++
 rtl/gf180mcu_osu_sc_gp12t3v3__dffn_1.sv | 11 +
 rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain.sv | 27 ++
 rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist.sv | 109 ++++++++++
 tb/tb_gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist.sv | 161 ++++++++++++++++
 6 files changed

// File: rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_pkg.sv
// Shared definitions for the dffn_1 chain BIST: FSM state encoding, LFSR
// feedback taps, default seed and a one-step LFSR helper.
package gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } bist_state_e;

    // Feedback taps s[15]^s[13]^s[12]^s[10].
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Fibonacci step: shift left, parity of tapped bits enters at s[0].
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_if.sv
// Control/status bundle of the chain BIST.
//   START/LEN/INJECT : run request, compare length, error injection (to BIST)
//   BUSY/DONE/PASS   : run status (from BIST)
//   ERR_CNT/FIRST_ERR_IDX : result counters (from BIST)
//   CHAIN_Q          : raw chain output for probing (from BIST)
interface gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_if #(
    parameter int CNT_W = 16
) ();
    logic             START;
    logic [CNT_W-1:0] LEN;
    logic             INJECT;
    logic             BUSY;
    logic             DONE;
    logic             PASS;
    logic [CNT_W-1:0] ERR_CNT;
    logic [CNT_W-1:0] FIRST_ERR_IDX;
    logic             CHAIN_Q;

    modport master (
        output START, LEN, INJECT,
        input  BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_IDX, CHAIN_Q
    );

    modport slave (
        input  START, LEN, INJECT,
        output BUSY, DONE, PASS, ERR_CNT, FIRST_ERR_IDX, CHAIN_Q
    );
endinterface

// File: rtl/gf180mcu_osu_sc_gp12t3v3__dffn_1.sv
// Behavioural model of the 12-track 3.3 V negative-edge D flip-flop.
//   D    : data in
//   CLKN : inverted clock; capture on its rising edge (falling edge of CLK)
//   Q    : data out (no reset, powers up unknown)
module gf180mcu_osu_sc_gp12t3v3__dffn_1 (
    input  logic D,
    input  logic CLKN,
    output logic Q
);
    always_ff @(posedge CLKN) Q <= D;
endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain.sv
// DEPTH dffn_1 cells in series, all clocked from the inverted block clock.
//   CLK : block clock
//   D   : chain input (stage 0)
//   Q   : chain output (stage DEPTH-1)
module gf180mcu_osu_sc_gp12t3v3__dffn_chain #(
    parameter int DEPTH = 8
) (
    input  logic CLK,
    input  logic D,
    output logic Q
);
    logic             CLKN;
    logic [DEPTH:0]   tap;

    assign CLKN   = ~CLK;
    assign tap[0] = D;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        gf180mcu_osu_sc_gp12t3v3__dffn_1 u_dff (
            .D    (tap[i]),
            .CLKN (CLKN),
            .Q    (tap[i+1])
        );
    end

    assign Q = tap[DEPTH];
endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist.sv
// BIST harness for a dffn_1 shift chain. A driver LFSR feeds the chain, a
// reference LFSR predicts its output, mismatches are counted.
//   CLK : block clock (control on rising edge, chain on falling edge)
//   RN  : asynchronous active-low reset
//   bus : control/status bundle (slave side)
module gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist
    import gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_pkg::*;
#(
    parameter int          DEPTH = 8,
    parameter logic [15:0] SEED  = DEFAULT_SEED,
    parameter int          CNT_W = 16
) (
    input  logic CLK,
    input  logic RN,
    gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_if.slave bus
);
    localparam int               FILL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bist_state_e      state_q, state_d;
    logic [FILL_W-1:0] fill_cnt;
    logic [CNT_W-1:0] idx, len_q, err_cnt, first_idx, err_d, first_d;
    logic [15:0]      drv, refl;
    logic             din_q, chain_q, pass_q, mismatch;

    // The launch bit is registered so that the bit of driver cycle j enters
    // stage 0 half a cycle later and is checked at the end of RUN cycle j.
    gf180mcu_osu_sc_gp12t3v3__dffn_chain #(.DEPTH(DEPTH)) u_chain (
        .CLK (CLK),
        .D   (din_q),
        .Q   (chain_q)
    );

    always_comb begin
        state_d  = state_q;
        mismatch = 1'b0;
        err_d    = err_cnt;
        first_d  = first_idx;
        case (state_q)
            ST_IDLE: if (bus.START) state_d = ST_FILL;
            ST_FILL: if (fill_cnt == FILL_W'(DEPTH - 1))
                         state_d = (len_q == '0) ? ST_DONE : ST_RUN;
            ST_RUN: begin
                mismatch = chain_q ^ refl[15];
                if (mismatch) begin
                    if (err_cnt != CNT_MAX) err_d = err_cnt + CNT_W'(1);
                    if (err_cnt == '0)      first_d = idx;
                end
                if (idx == len_q - CNT_W'(1)) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            fill_cnt  <= '0;
            idx       <= '0;
            len_q     <= '0;
            err_cnt   <= '0;
            first_idx <= '1;
            drv       <= SEED;
            refl      <= SEED;
            din_q     <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_cnt   <= err_d;
            first_idx <= first_d;
            case (state_q)
                ST_IDLE: if (bus.START) begin
                    drv       <= SEED;
                    refl      <= SEED;
                    len_q     <= bus.LEN;
                    fill_cnt  <= '0;
                    idx       <= '0;
                    err_cnt   <= '0;
                    first_idx <= '1;
                    pass_q    <= 1'b0;
                end
                ST_FILL: begin
                    drv      <= lfsr_step(drv);
                    din_q    <= drv[15] ^ bus.INJECT;
                    fill_cnt <= fill_cnt + FILL_W'(1);
                end
                ST_RUN: begin
                    drv   <= lfsr_step(drv);
                    din_q <= drv[15] ^ bus.INJECT;
                    refl  <= lfsr_step(refl);
                    idx   <= idx + CNT_W'(1);
                end
                default: ;
            endcase
            // Verdict is taken from the post-compare count so it appears
            // together with the DONE pulse.
            if (state_q != ST_DONE && state_d == ST_DONE)
                pass_q <= (err_d == '0);
        end
    end

    assign bus.BUSY          = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign bus.DONE          = (state_q == ST_DONE);
    assign bus.PASS          = pass_q;
    assign bus.ERR_CNT       = err_cnt;
    assign bus.FIRST_ERR_IDX = first_idx;
    assign bus.CHAIN_Q       = chain_q;
endmodule

// File: tb/tb_gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist.sv
module tb_gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist;

    logic CLK = 1'b0;
    logic RN  = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_if #(.CNT_W(16)) bus_a ();
    gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist_if #(.CNT_W(4))  bus_b ();

    gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist #(.DEPTH(8), .SEED(16'hACE1), .CNT_W(16)) u_a (
        .CLK (CLK), .RN (RN), .bus (bus_a)
    );
    gf180mcu_osu_sc_gp12t3v3__dffn_chain_bist #(.DEPTH(8), .SEED(16'hACE1), .CNT_W(4)) u_b (
        .CLK (CLK), .RN (RN), .bus (bus_b)
    );

    typedef struct {
        int          len;
        int          inj_s;     // first driver cycle with INJECT (FILL 0 = 0)
        int          inj_n;     // INJECT length in cycles, 0 = none
        bit          hold;      // keep START high and disturb LEN while busy
        int          exp_cyc;   // START cycle .. DONE cycle inclusive
        int          exp_err;
        logic [15:0] exp_first;
        bit          exp_pass;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int cyc;
        int dc;
        @(posedge CLK); #1;
        bus_a.START  = 1'b1;
        bus_a.LEN    = v.len[15:0];
        bus_a.INJECT = 1'b0;
        cyc = 1;
        while (1) begin
            @(posedge CLK); #1;
            cyc++;
            if (!v.hold) bus_a.START = 1'b0;
            else         bus_a.LEN   = 16'h0003;
            dc = cyc - 2;
            bus_a.INJECT = (v.inj_n > 0) && (dc >= v.inj_s) && (dc < v.inj_s + v.inj_n);
            if (bus_a.DONE || cyc > 400) break;
        end
        bus_a.START  = 1'b0;
        bus_a.INJECT = 1'b0;
        chk($sformatf("v%0d_timeout", id), 32'(cyc <= 400), 32'd1);
        chk($sformatf("v%0d_cycles", id), cyc, v.exp_cyc);
        chk($sformatf("v%0d_err", id), bus_a.ERR_CNT, v.exp_err);
        chk($sformatf("v%0d_first", id), bus_a.FIRST_ERR_IDX, v.exp_first);
        chk($sformatf("v%0d_pass", id), bus_a.PASS, v.exp_pass);
        @(posedge CLK); #1;
        chk($sformatf("v%0d_done_pulse", id), bus_a.DONE, 1'b0);
        chk($sformatf("v%0d_pass_hold", id), bus_a.PASS, v.exp_pass);
        chk($sformatf("v%0d_err_hold", id), bus_a.ERR_CNT, v.exp_err);
    endtask

    initial begin
        int first_seen;
        int gap;
        int cyc;

        vecs[0] = '{100, 0, 0, 1'b0, 110, 0, 16'hFFFF, 1'b1};
        vecs[1] = '{100, 3, 1, 1'b0, 110, 1, 16'd3,    1'b0};
        vecs[2] = '{100, 28, 5, 1'b0, 110, 5, 16'd28,  1'b0};
        vecs[3] = '{0,   0, 0, 1'b1, 10,  0, 16'hFFFF, 1'b1};
        vecs[4] = '{5,   4, 1, 1'b0, 15,  1, 16'd4,    1'b0};
        vecs[5] = '{5,   5, 1, 1'b0, 15,  0, 16'hFFFF, 1'b1};
        vecs[6] = '{1,   0, 1, 1'b0, 11,  1, 16'd0,    1'b0};

        bus_a.START = 1'b0; bus_a.LEN = '0; bus_a.INJECT = 1'b0;
        bus_b.START = 1'b0; bus_b.LEN = '0; bus_b.INJECT = 1'b0;

        // Reset state
        #23;
        chk("rst_busy",  bus_a.BUSY, 1'b0);
        chk("rst_done",  bus_a.DONE, 1'b0);
        chk("rst_pass",  bus_a.PASS, 1'b0);
        chk("rst_err",   bus_a.ERR_CNT, 16'd0);
        chk("rst_first", bus_a.FIRST_ERR_IDX, 16'hFFFF);
        chk("rst_b_err", bus_b.ERR_CNT, 4'd0);
        chk("rst_b_first", bus_b.FIRST_ERR_IDX, 4'hF);
        @(posedge CLK); #1;
        RN = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // START held high in IDLE relaunches a run after every DONE.
        @(posedge CLK); #1;
        bus_a.START = 1'b1; bus_a.LEN = 16'd0;
        first_seen = -1; gap = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge CLK); #1;
            if (bus_a.DONE) begin
                if (first_seen < 0) first_seen = c;
                else begin gap = c - first_seen; break; end
            end
        end
        bus_a.START = 1'b0;
        chk("relaunch_gap", gap, 10);
        chk("relaunch_pass", bus_a.PASS, 1'b1);
        @(posedge CLK); #1;

        // Narrow counters: every compare fails, count tops out at all-ones.
        @(posedge CLK); #1;
        bus_b.START = 1'b1; bus_b.LEN = 4'hF; bus_b.INJECT = 1'b1;
        cyc = 1;
        while (1) begin
            @(posedge CLK); #1;
            cyc++;
            bus_b.START = 1'b0;
            if (bus_b.DONE || cyc > 400) break;
        end
        bus_b.INJECT = 1'b0;
        chk("sat_cycles", cyc, 25);
        chk("sat_err",   bus_b.ERR_CNT, 4'hF);
        chk("sat_first", bus_b.FIRST_ERR_IDX, 4'h0);
        chk("sat_pass",  bus_b.PASS, 1'b0);

        // Reset in the middle of a run, then a clean run over stale chain data.
        @(posedge CLK); #1;
        bus_a.START = 1'b1; bus_a.LEN = 16'd100;
        for (int c = 2; c <= 30; c++) begin
            @(posedge CLK); #1;
            bus_a.START  = 1'b0;
            bus_a.INJECT = (c == 5);   // driver cycle 3
        end
        bus_a.INJECT = 1'b0;
        chk("mid_busy",  bus_a.BUSY, 1'b1);
        chk("mid_err",   bus_a.ERR_CNT, 16'd1);
        chk("mid_first", bus_a.FIRST_ERR_IDX, 16'd3);
        RN = 1'b0;
        #2;
        chk("arst_busy",  bus_a.BUSY, 1'b0);
        chk("arst_done",  bus_a.DONE, 1'b0);
        chk("arst_pass",  bus_a.PASS, 1'b0);
        chk("arst_err",   bus_a.ERR_CNT, 16'd0);
        chk("arst_first", bus_a.FIRST_ERR_IDX, 16'hFFFF);
        @(posedge CLK); #1;
        chk("arst_hold_busy", bus_a.BUSY, 1'b0);
        RN = 1'b1;
        run_vec(vecs[0], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
